// File: rtl/adc_sample_framer.sv
`default_nettype none
// ============================================================================
// adc_sample_framer : ADS1201 Sync generator, sample capture, FIFO and
//                     5-byte frame serialiser onto a valid/ready byte stream.
// Revision 1.0
// ============================================================================
module adc_sample_framer #(
    parameter int SYNC_PERIOD   = 512,
    parameter int SYNC_HIGH     = 4,
    parameter int CAPTURE_DELAY = 6,
    parameter int FIFO_AW       = 3
) (
    input  logic        nReset,
    input  logic        Clk,
    input  logic        Enable,
    output logic        Sync,
    input  logic [23:0] Sample_In,
    output logic [7:0]  Byte_Data,
    output logic        Byte_Valid,
    input  logic        Byte_Ready,
    output logic        Overflow,
    input  logic        Clear_Overflow
);

    localparam int              c_CNT_W     = $clog2(SYNC_PERIOD);
    localparam int              c_DEPTH_INT = 2 ** FIFO_AW;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(SYNC_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_SYNC_HIGH = c_CNT_W'(SYNC_HIGH);
    localparam logic [c_CNT_W-1:0] c_CAPTURE   = c_CNT_W'(CAPTURE_DELAY);
    localparam logic [FIFO_AW:0]   c_DEPTH     = (FIFO_AW + 1)'(c_DEPTH_INT);
    localparam logic [7:0]         c_HDR       = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_SEQ  = 3'd2,
        S_B2   = 3'd3,
        S_B1   = 3'd4,
        S_B0   = 3'd5
    } state_t;

    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         r_seq;
    logic [31:0]        r_mem [c_DEPTH_INT];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_fill;
    logic [31:0]        r_frame;
    state_t             r_state;

    logic        w_capture;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_handshake;
    logic [31:0] w_fifo_rd;
    state_t      w_state_next;
    logic [31:0] w_frame_next;
    logic [7:0]  w_data_next;
    logic        w_valid_next;

    // Period counter and Sync strobe; Sync is registered from the pre-increment count
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_count <= '0;
            Sync    <= 1'b0;
        end else if (!Enable) begin
            r_count <= '0;
            Sync    <= 1'b0;
        end else begin
            r_count <= (r_count == c_CNT_LAST) ? '0 : r_count + 1'b1;
            Sync    <= (r_count < c_SYNC_HIGH);
        end
    end

    assign w_capture   = Enable && (r_count == c_CAPTURE);
    assign w_full      = (r_fill == c_DEPTH);
    assign w_empty     = (r_fill == '0);
    assign w_push      = w_capture && (!w_full || w_pop);
    assign w_drop      = w_capture && !w_push;
    assign w_fifo_rd   = r_mem[r_rd_ptr];
    assign w_handshake = Byte_Valid && Byte_Ready;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_seq, Sample_In};
        end
    end

    // Seq advances on dropped captures too, so gaps show up downstream
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_seq    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            if (w_capture) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_drop) begin
                Overflow <= 1'b1;
            end else if (Clear_Overflow) begin
                Overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            Byte_Data  <= '0;
            Byte_Valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_frame    <= w_frame_next;
            Byte_Data  <= w_data_next;
            Byte_Valid <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_next = r_frame;
        w_data_next  = Byte_Data;
        w_valid_next = Byte_Valid;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_frame_next = w_fifo_rd;
                    w_state_next = S_HDR;
                    w_data_next  = c_HDR;
                    w_valid_next = 1'b1;
                end
            end
            S_HDR: begin
                if (w_handshake) begin
                    w_state_next = S_SEQ;
                    w_data_next  = r_frame[31:24];
                end
            end
            S_SEQ: begin
                if (w_handshake) begin
                    w_state_next = S_B2;
                    w_data_next  = r_frame[23:16];
                end
            end
            S_B2: begin
                if (w_handshake) begin
                    w_state_next = S_B1;
                    w_data_next  = r_frame[15:8];
                end
            end
            S_B1: begin
                if (w_handshake) begin
                    w_state_next = S_B0;
                    w_data_next  = r_frame[7:0];
                end
            end
            S_B0: begin
                // Chain straight into the next header when more samples wait
                if (w_handshake) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_frame_next = w_fifo_rd;
                        w_state_next = S_HDR;
                        w_data_next  = c_HDR;
                    end else begin
                        w_state_next = S_IDLE;
                        w_valid_next = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_framer.sv
`default_nettype none
// ============================================================================
// tb_adc_sample_framer : directed bench for adc_sample_framer.
// Revision 1.0
// ============================================================================
module tb_adc_sample_framer;

    logic        nReset;
    logic        Clk;
    logic        Enable;
    logic        Sync;
    logic [23:0] Sample_In;
    logic [7:0]  Byte_Data;
    logic        Byte_Valid;
    logic        Byte_Ready;
    logic        Overflow;
    logic        Clear_Overflow;

    int         k;
    int         n_checks;
    int         n_pass;
    logic [7:0] bq [$];
    int         kq [$];

    adc_sample_framer #(
        .SYNC_PERIOD   (32),
        .SYNC_HIGH     (4),
        .CAPTURE_DELAY (6),
        .FIFO_AW       (3)
    ) dut (
        .nReset         (nReset),
        .Clk            (Clk),
        .Enable         (Enable),
        .Sync           (Sync),
        .Sample_In      (Sample_In),
        .Byte_Data      (Byte_Data),
        .Byte_Valid     (Byte_Valid),
        .Byte_Ready     (Byte_Ready),
        .Overflow       (Overflow),
        .Clear_Overflow (Clear_Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance one clock, drive Byte_Ready for the next edge, log the byte that edge will accept
    task automatic step(input logic rdy);
        @(posedge Clk);
        #1;
        k++;
        Byte_Ready = rdy;
        if (Byte_Valid && Byte_Ready) begin
            bq.push_back(Byte_Data);
            kq.push_back(k);
        end
    endtask

    task automatic do_reset();
        nReset         = 1'b0;
        Enable         = 1'b0;
        Byte_Ready     = 1'b0;
        Clear_Overflow = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        nReset = 1'b1;
        k      = 0;
        bq.delete();
        kq.delete();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({Sync, Byte_Valid, Overflow, Byte_Data} !== 11'h000) begin
            $display("FAIL reset_values: got Sync=%b Valid=%b Ovf=%b Data=%h, expected all 0",
                     Sync, Byte_Valid, Overflow, Byte_Data);
        end else n_pass++;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        k      = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            n_checks++;
            if (Sync !== 1'b0 || Byte_Valid !== 1'b0) begin
                $display("FAIL idle_disabled: cycle %0d Sync=%b Valid=%b, expected 0 0",
                         k, Sync, Byte_Valid);
            end else n_pass++;
        end
    endtask

    task automatic test_sync_frames();
        logic [7:0] exp_b [10] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56,
                                   8'hA5, 8'h01, 8'h12, 8'h34, 8'h56};
        int         exp_k [10] = '{8, 9, 10, 11, 12, 40, 41, 42, 43, 44};
        logic       exp_sync;
        do_reset();
        Enable     = 1'b1;
        Sample_In  = 24'h123456;
        Byte_Ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step(1'b1);
            exp_sync = ((k % 32) >= 1) && ((k % 32) <= 4);
            n_checks++;
            if (Sync !== exp_sync) begin
                $display("FAIL sync_pattern: cycle %0d got %b expected %b", k, Sync, exp_sync);
            end else n_pass++;
        end
        n_checks++;
        if (bq.size() != 10) begin
            $display("FAIL frame_count: got %0d bytes expected 10", bq.size());
        end else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp_b[i] || kq[i] != exp_k[i]) begin
                $display("FAIL frame_byte[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                         i, (i < bq.size()) ? bq[i] : 8'hxx, (i < kq.size()) ? kq[i] : -1,
                         exp_b[i], exp_k[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_ready_toggle();
        logic [7:0] exp_b [5] = '{8'hA5, 8'h00, 8'hFE, 8'hDC, 8'hBA};
        logic       prev_stall;
        logic [7:0] prev_data;
        do_reset();
        Enable     = 1'b1;
        Sample_In  = 24'hFEDCBA;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int i = 0; i < 30; i++) begin
            step(k[0] ? 1'b0 : 1'b1);
            if (prev_stall) begin
                n_checks++;
                if (Byte_Valid !== 1'b1 || Byte_Data !== prev_data) begin
                    $display("FAIL stall_stable: cycle %0d got V=%b D=%h expected V=1 D=%h",
                             k, Byte_Valid, Byte_Data, prev_data);
                end else n_pass++;
            end
            prev_stall = Byte_Valid && !Byte_Ready;
            prev_data  = Byte_Data;
        end
        n_checks++;
        if (bq.size() != 5) begin
            $display("FAIL toggle_count: got %0d bytes expected 5", bq.size());
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp_b[i]) begin
                $display("FAIL toggle_byte[%0d]: got %h expected %h",
                         i, (i < bq.size()) ? bq[i] : 8'hxx, exp_b[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        int         f;
        do_reset();
        Enable    = 1'b1;
        Sample_In = 24'hABCDEF;
        while (k < 294) step(1'b0);
        n_checks++;
        if (Overflow !== 1'b0 || Byte_Valid !== 1'b1 || Byte_Data !== 8'hA5) begin
            $display("FAIL full_no_drop: got Ovf=%b V=%b D=%h expected 0 1 a5",
                     Overflow, Byte_Valid, Byte_Data);
        end else n_pass++;
        step(1'b0);
        n_checks++;
        if (Overflow !== 1'b1) begin
            $display("FAIL overflow_set: got %b expected 1", Overflow);
        end else n_pass++;
        while (k < 355) step(1'b1);
        n_checks++;
        if (bq.size() != 50) begin
            $display("FAIL drain_count: got %0d bytes expected 50", bq.size());
        end else n_pass++;
        for (int i = 0; i < 50; i++) begin
            f = i / 5;
            case (i % 5)
                0:       exp = 8'hA5;
                1:       exp = (f < 9) ? 8'(f) : 8'd10;
                2:       exp = 8'hAB;
                3:       exp = 8'hCD;
                default: exp = 8'hEF;
            endcase
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp) begin
                $display("FAIL drain_byte[%0d]: got %h expected %h",
                         i, (i < bq.size()) ? bq[i] : 8'hxx, exp);
            end else n_pass++;
        end
        n_checks++;
        if (Overflow !== 1'b1) begin
            $display("FAIL overflow_sticky: got %b expected 1", Overflow);
        end else n_pass++;
        Clear_Overflow = 1'b1;
        step(1'b1);
        Clear_Overflow = 1'b0;
        n_checks++;
        if (Overflow !== 1'b0) begin
            $display("FAIL overflow_clear: got %b expected 0", Overflow);
        end else n_pass++;
    endtask

    task automatic test_enable_drop();
        logic [7:0] exp;
        do_reset();
        Enable    = 1'b1;
        Sample_In = 24'h111111;
        while (k < 71) step(1'b0);
        while (k < 74) step(1'b1);
        n_checks++;
        if (bq.size() != 3 || Byte_Data !== 8'h11) begin
            $display("FAIL enable_at_b2: got %0d bytes D=%h expected 3 bytes D=11",
                     bq.size(), Byte_Data);
        end else n_pass++;
        Enable = 1'b0;
        while (k < 154) begin
            step(1'b1);
            n_checks++;
            if (Sync !== 1'b0) begin
                $display("FAIL sync_disabled: cycle %0d got %b expected 0", k, Sync);
            end else n_pass++;
        end
        n_checks++;
        if (bq.size() != 15 || Byte_Valid !== 1'b0) begin
            $display("FAIL enable_drain_count: got %0d bytes V=%b expected 15 bytes V=0",
                     bq.size(), Byte_Valid);
        end else n_pass++;
        for (int i = 0; i < 15; i++) begin
            case (i % 5)
                0:       exp = 8'hA5;
                1:       exp = 8'(i / 5);
                default: exp = 8'h11;
            endcase
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp) begin
                $display("FAIL enable_drain_byte[%0d]: got %h expected %h",
                         i, (i < bq.size()) ? bq[i] : 8'hxx, exp);
            end else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [5] = '{8'hA5, 8'h00, 8'h22, 8'h22, 8'h22};
        do_reset();
        Enable    = 1'b1;
        Sample_In = 24'h222222;
        while (k < 295) step(1'b0);
        n_checks++;
        if (Overflow !== 1'b1) begin
            $display("FAIL pre_reset_overflow: got %b expected 1", Overflow);
        end else n_pass++;
        step(1'b1);
        step(1'b1);
        n_checks++;
        if (Byte_Valid !== 1'b1 || Byte_Data !== 8'h00) begin
            $display("FAIL seq_byte_before_reset: got V=%b D=%h expected 1 00",
                     Byte_Valid, Byte_Data);
        end else n_pass++;
        #1;
        nReset = 1'b0;
        #1;
        n_checks++;
        if (Byte_Valid !== 1'b0 || Overflow !== 1'b0 || Sync !== 1'b0 || Byte_Data !== 8'h00) begin
            $display("FAIL async_reset: got V=%b Ovf=%b Sync=%b D=%h expected 0 0 0 00",
                     Byte_Valid, Overflow, Sync, Byte_Data);
        end else n_pass++;
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        k      = 0;
        bq.delete();
        kq.delete();
        while (k < 20) step(1'b1);
        n_checks++;
        if (bq.size() != 5) begin
            $display("FAIL post_reset_count: got %0d bytes expected 5", bq.size());
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp_b[i] || kq[i] != 8 + i) begin
                $display("FAIL post_reset_byte[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                         i, (i < bq.size()) ? bq[i] : 8'hxx, (i < kq.size()) ? kq[i] : -1,
                         exp_b[i], 8 + i);
            end else n_pass++;
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        int         f;
        do_reset();
        Enable    = 1'b1;
        Sample_In = 24'h345678;
        while (k < 7) step(1'b0);
        while (k < 11) step(1'b1);
        while (k < 293) step(1'b0);
        bq.delete();
        kq.delete();
        step(1'b1);
        step(1'b1);
        n_checks++;
        if (Overflow !== 1'b0) begin
            $display("FAIL full_push_with_pop: got Ovf=%b expected 0", Overflow);
        end else n_pass++;
        while (k < 339) step(1'b1);
        n_checks++;
        if (bq.size() != 46) begin
            $display("FAIL full_drain_count: got %0d bytes expected 46", bq.size());
        end else n_pass++;
        for (int i = 0; i < 46; i++) begin
            if (i == 0) begin
                exp = 8'h78;
            end else begin
                f = (i - 1) / 5;
                case ((i - 1) % 5)
                    0:       exp = 8'hA5;
                    1:       exp = 8'(f + 1);
                    2:       exp = 8'h34;
                    3:       exp = 8'h56;
                    default: exp = 8'h78;
                endcase
            end
            n_checks++;
            if (i >= bq.size() || bq[i] !== exp) begin
                $display("FAIL full_drain_byte[%0d]: got %h expected %h",
                         i, (i < bq.size()) ? bq[i] : 8'hxx, exp);
            end else n_pass++;
        end
        n_checks++;
        if (Overflow !== 1'b0) begin
            $display("FAIL full_drain_overflow: got %b expected 0", Overflow);
        end else n_pass++;
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        k              = 0;
        nReset         = 1'b1;
        Enable         = 1'b0;
        Sample_In      = 24'h000000;
        Byte_Ready     = 1'b0;
        Clear_Overflow = 1'b0;
        #2;
        nReset = 1'b0;
        test_reset();
        test_sync_frames();
        test_ready_toggle();
        test_overflow();
        test_enable_drop();
        test_reset_mid_frame();
        test_full_push_pop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
